// File: rtl/issue_read_operands_pkg.sv
// issue_read_operands_pkg: shared types and sizes for the issue/operand-read stage
package issue_read_operands_pkg;
  localparam int NrSbEntries     = 8;
  localparam int ScoreboardIndex = $clog2(NrSbEntries);
  localparam int WriteBackPorts  = 2;
  localparam int XLEN            = 32;

  typedef enum logic [2:0] {FU_NONE, FU_ALU, FU_BU, FU_MDU, FU_CSR, FU_LSU} fu_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_BEQ, OP_BNE, OP_MUL, OP_DIV,
    OP_CSRRW, OP_LW, OP_SW, OP_SB
  } fu_op_t;

  typedef struct packed {
    logic [ScoreboardIndex-1:0] idx;
    fu_t                        fu;
    fu_op_t                     operation;
    logic [4:0]                 rs1;
    logic [4:0]                 rs2;
    logic [4:0]                 rd;
    logic [XLEN-1:0]            imm;
    logic [XLEN-1:0]            pc;
    logic                       is_rv16;
    logic                       use_imm;
    logic                       use_pc;
  } issue_entry_t;

  typedef struct packed {
    fu_t                        fu;
    fu_op_t                     operation;
    logic [XLEN-1:0]            operand_a;
    logic [XLEN-1:0]            operand_b;
    logic [XLEN-1:0]            imm;
    logic [ScoreboardIndex-1:0] idx;
  } fu_data_t;

  typedef struct packed {
    logic                       valid;
    logic [ScoreboardIndex-1:0] idx;
    logic [XLEN-1:0]            data;
  } writeback_t;

  // Stores carry the address offset in imm and need rs2 as store data.
  function automatic logic is_store(fu_op_t op);
    return op == OP_SW || op == OP_SB;
  endfunction
endpackage

// File: rtl/issue_read_operands_regfile.sv
// issue_read_operands_regfile: 32xXLEN register file, 2 async read ports, 1 sync write port, x0 = 0
// Ports: i_clk/i_rst_n clock and async active-low reset; i_we/i_waddr/i_wdata write port;
//   i_raddr_a/o_rdata_a and i_raddr_b/o_rdata_b combinational read ports.
module issue_read_operands_regfile
  import issue_read_operands_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr_a,
  input  logic [4:0]      i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);
  logic [XLEN-1:0] r_mem [32];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_mem <= '{default: '0};
    else if (i_we && i_waddr != '0) r_mem[i_waddr] <= i_wdata;

  assign o_rdata_a = i_raddr_a == '0 ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b = i_raddr_b == '0 ? '0 : r_mem[i_raddr_b];
endmodule

// File: rtl/issue_read_operands.sv
// issue_read_operands: resolve rs1/rs2 and dispatch one decoded instruction per cycle into ex_stage
// Ports: i_clk/i_rst_n clock and async active-low reset; i_flush kills dispatch and pending state;
//   i_issue_valid/o_issue_ready/i_issue_instr issue handshake; i_flu_ready/i_lsu_ready FU readiness;
//   o_fu_data/o_pc/o_is_rv16 registered payload; o_{alu,bu,mdu,csr,lsu}_valid one-cycle dispatch pulses;
//   i_wb writeback results; i_commit_valid/idx/rd/data retiring head entry.
module issue_read_operands
  import issue_read_operands_pkg::*;
(
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  input  logic                                i_issue_valid,
  output logic                                o_issue_ready,
  input  issue_entry_t                        i_issue_instr,
  input  logic                                i_flu_ready,
  input  logic                                i_lsu_ready,
  output fu_data_t                            o_fu_data,
  output logic [XLEN-1:0]                     o_pc,
  output logic                                o_is_rv16,
  output logic                                o_alu_valid,
  output logic                                o_bu_valid,
  output logic                                o_mdu_valid,
  output logic                                o_csr_valid,
  output logic                                o_lsu_valid,
  input  writeback_t [WriteBackPorts-1:0]     i_wb,
  input  logic                                i_commit_valid,
  input  logic [ScoreboardIndex-1:0]          i_commit_idx,
  input  logic [4:0]                          i_commit_rd,
  input  logic [XLEN-1:0]                     i_commit_data
);
  logic [31:0]                r_pending;
  logic [ScoreboardIndex-1:0] r_pend_idx [32];
  logic [NrSbEntries-1:0]     r_rb_valid;
  logic [XLEN-1:0]            r_rb_data [NrSbEntries];
  logic                       r_mask_flu;
  logic                       r_mask_lsu;
  logic [4:0]                 w_rs [2];
  logic [XLEN-1:0]            w_rf [2];
  logic [XLEN-1:0]            w_val [2];
  logic [1:0]                 w_rdy;
  logic                       w_store;
  logic                       w_fu_ok;
  logic                       w_accept;
  fu_t                        w_fu;

  assign w_rs[0] = i_issue_instr.rs1;
  assign w_rs[1] = i_issue_instr.rs2;
  assign w_fu    = i_issue_instr.fu;

  issue_read_operands_regfile u_regfile (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (i_commit_valid),
    .i_waddr   (i_commit_rd),
    .i_wdata   (i_commit_data),
    .i_raddr_a (w_rs[0]),
    .i_raddr_b (w_rs[1]),
    .o_rdata_a (w_rf[0]),
    .o_rdata_b (w_rf[1])
  );

  // Source priority: x0, committed state (commit bypassed), then in-flight producer
  // via writeback ports (scanned high to low so port 0 wins) or the result buffer.
  always_comb
    for (int s = 0; s < 2; s++) begin
      w_val[s] = '0;
      w_rdy[s] = 1'b0;
      if (w_rs[s] == '0) w_rdy[s] = 1'b1;
      else if (!r_pending[w_rs[s]]) begin
        w_rdy[s] = 1'b1;
        w_val[s] = (i_commit_valid && i_commit_rd == w_rs[s]) ? i_commit_data : w_rf[s];
      end else begin
        w_rdy[s] = r_rb_valid[r_pend_idx[w_rs[s]]];
        w_val[s] = r_rb_data[r_pend_idx[w_rs[s]]];
        for (int k = WriteBackPorts - 1; k >= 0; k--)
          if (i_wb[k].valid && i_wb[k].idx == r_pend_idx[w_rs[s]]) begin
            w_rdy[s] = 1'b1;
            w_val[s] = i_wb[k].data;
          end
      end
    end

  // ex_stage ready lags a registered dispatch by a cycle, so mask it right after MDU/CSR/LSU.
  assign w_store  = w_fu == FU_LSU && is_store(i_issue_instr.operation);
  assign w_fu_ok  = w_fu == FU_LSU ? i_lsu_ready && !r_mask_lsu : i_flu_ready && !r_mask_flu;
  assign w_accept = i_issue_valid && w_fu_ok && !i_flush
                 && (i_issue_instr.use_pc || w_rdy[0])
                 && ((i_issue_instr.use_imm && !w_store) || w_rdy[1]);
  assign o_issue_ready = w_accept;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_fu_data   <= '0;
      o_pc        <= '0;
      o_is_rv16   <= 1'b0;
      o_alu_valid <= 1'b0;
      o_bu_valid  <= 1'b0;
      o_mdu_valid <= 1'b0;
      o_csr_valid <= 1'b0;
      o_lsu_valid <= 1'b0;
      r_mask_flu  <= 1'b0;
      r_mask_lsu  <= 1'b0;
    end else begin
      o_alu_valid <= w_accept && w_fu == FU_ALU;
      o_bu_valid  <= w_accept && w_fu == FU_BU;
      o_mdu_valid <= w_accept && w_fu == FU_MDU;
      o_csr_valid <= w_accept && w_fu == FU_CSR;
      o_lsu_valid <= w_accept && w_fu == FU_LSU;
      r_mask_flu  <= w_accept && (w_fu == FU_MDU || w_fu == FU_CSR);
      r_mask_lsu  <= w_accept && w_fu == FU_LSU;
      if (w_accept) begin
        o_fu_data <= '{fu: w_fu, operation: i_issue_instr.operation,
                       operand_a: i_issue_instr.use_pc ? i_issue_instr.pc : w_val[0],
                       operand_b: (i_issue_instr.use_imm && !w_store) ? i_issue_instr.imm : w_val[1],
                       imm: i_issue_instr.imm, idx: i_issue_instr.idx};
        o_pc      <= i_issue_instr.pc;
        o_is_rv16 <= i_issue_instr.is_rv16;
      end
    end

  // Later assignments take precedence: writeback sets, commit clears, a new accept owns rd last.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pending  <= '0;
      r_pend_idx <= '{default: '0};
      r_rb_valid <= '0;
      r_rb_data  <= '{default: '0};
    end else if (i_flush) begin
      r_pending  <= '0;
      r_rb_valid <= '0;
    end else begin
      for (int k = 0; k < WriteBackPorts; k++)
        if (i_wb[k].valid) begin
          r_rb_valid[i_wb[k].idx] <= 1'b1;
          r_rb_data[i_wb[k].idx]  <= i_wb[k].data;
        end
      if (i_commit_valid) begin
        r_rb_valid[i_commit_idx] <= 1'b0;
        if (r_pend_idx[i_commit_rd] == i_commit_idx) r_pending[i_commit_rd] <= 1'b0;
      end
      if (w_accept && i_issue_instr.rd != '0) begin
        r_pending[i_issue_instr.rd]  <= 1'b1;
        r_pend_idx[i_issue_instr.rd] <= i_issue_instr.idx;
        r_rb_valid[i_issue_instr.idx] <= 1'b0;
      end
    end
endmodule

// File: tb/tb_issue_read_operands.sv
// tb_issue_read_operands: directed scenarios plus randomized traffic against a behavioural model
module tb_issue_read_operands;
  import issue_read_operands_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush, issue_valid, issue_ready, flu_ready, lsu_ready, commit_valid;
  issue_entry_t instr;
  writeback_t [WriteBackPorts-1:0] wb;
  logic [ScoreboardIndex-1:0] commit_idx;
  logic [4:0] commit_rd;
  logic [XLEN-1:0] commit_data;
  fu_data_t fu_data;
  logic [XLEN-1:0] pc;
  logic is_rv16, alu_v, bu_v, mdu_v, csr_v, lsu_v;
  logic [4:0] vals;
  int checks = 0;
  int failures = 0;

  assign vals = {alu_v, bu_v, mdu_v, csr_v, lsu_v};
  always #5 clk = ~clk;

  issue_read_operands dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_issue_valid(issue_valid), .o_issue_ready(issue_ready), .i_issue_instr(instr),
    .i_flu_ready(flu_ready), .i_lsu_ready(lsu_ready),
    .o_fu_data(fu_data), .o_pc(pc), .o_is_rv16(is_rv16),
    .o_alu_valid(alu_v), .o_bu_valid(bu_v), .o_mdu_valid(mdu_v), .o_csr_valid(csr_v), .o_lsu_valid(lsu_v),
    .i_wb(wb), .i_commit_valid(commit_valid), .i_commit_idx(commit_idx),
    .i_commit_rd(commit_rd), .i_commit_data(commit_data)
  );

  // Reference model: architectural state and in-flight producers as plain arrays.
  logic [XLEN-1:0]            m_rf [32];
  bit                         m_pend [32];
  logic [ScoreboardIndex-1:0] m_pidx [32];
  bit                         m_rbv [NrSbEntries];
  logic [XLEN-1:0]            m_rbd [NrSbEntries];
  fu_t                        m_prev_fu;
  bit                         m_ready;
  logic [XLEN-1:0]            m_a, m_b, exp_pc;
  logic [4:0]                 exp_v;
  fu_data_t                   exp_fu;
  logic                       exp_rv16;

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_pend[i] = 0; m_pidx[i] = '0; end
    for (int e = 0; e < NrSbEntries; e++) begin m_rbv[e] = 0; m_rbd[e] = '0; end
    m_prev_fu = FU_NONE; m_ready = 0; exp_v = '0; exp_fu = '0; exp_pc = '0; exp_rv16 = 1'b0;
  endfunction

  function automatic void m_operand(input logic [4:0] rs, output bit ok, output logic [XLEN-1:0] v);
    ok = 0; v = '0;
    if (rs == 0) ok = 1;
    else if (!m_pend[rs]) begin
      ok = 1;
      v = (commit_valid && commit_rd == rs) ? commit_data : m_rf[rs];
    end else begin
      for (int k = 0; k < WriteBackPorts; k++)
        if (!ok && wb[k].valid && wb[k].idx == m_pidx[rs]) begin ok = 1; v = wb[k].data; end
      if (!ok && m_rbv[m_pidx[rs]]) begin ok = 1; v = m_rbd[m_pidx[rs]]; end
    end
  endfunction

  function automatic void m_eval();
    bit ok1, ok2, st, fok;
    logic [XLEN-1:0] v1, v2;
    m_operand(instr.rs1, ok1, v1);
    m_operand(instr.rs2, ok2, v2);
    st = instr.fu == FU_LSU && (instr.operation == OP_SW || instr.operation == OP_SB);
    fok = instr.fu == FU_LSU ? (lsu_ready && m_prev_fu != FU_LSU)
                             : (flu_ready && m_prev_fu != FU_MDU && m_prev_fu != FU_CSR);
    m_ready = issue_valid && fok && !flush && (instr.use_pc || ok1) && ((instr.use_imm && !st) || ok2);
    m_a = instr.use_pc ? instr.pc : v1;
    m_b = (instr.use_imm && !st) ? instr.imm : v2;
  endfunction

  function automatic void m_edge();
    exp_v = '0;
    if (m_ready) begin
      case (instr.fu)
        FU_ALU:  exp_v = 5'b10000;
        FU_BU:   exp_v = 5'b01000;
        FU_MDU:  exp_v = 5'b00100;
        FU_CSR:  exp_v = 5'b00010;
        FU_LSU:  exp_v = 5'b00001;
        default: exp_v = 5'b00000;
      endcase
      exp_fu = '{fu: instr.fu, operation: instr.operation, operand_a: m_a, operand_b: m_b,
                 imm: instr.imm, idx: instr.idx};
      exp_pc = instr.pc;
      exp_rv16 = instr.is_rv16;
    end
    m_prev_fu = m_ready ? instr.fu : FU_NONE;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      for (int e = 0; e < NrSbEntries; e++) m_rbv[e] = 0;
    end else begin
      for (int k = 0; k < WriteBackPorts; k++)
        if (wb[k].valid) begin m_rbv[wb[k].idx] = 1; m_rbd[wb[k].idx] = wb[k].data; end
      if (commit_valid) begin
        m_rbv[commit_idx] = 0;
        if (m_pend[commit_rd] && m_pidx[commit_rd] == commit_idx) m_pend[commit_rd] = 0;
      end
      if (m_ready && instr.rd != 0) begin
        m_pend[instr.rd] = 1; m_pidx[instr.rd] = instr.idx; m_rbv[instr.idx] = 0;
      end
    end
    if (commit_valid && commit_rd != 0) m_rf[commit_rd] = commit_data;
  endfunction

  function automatic issue_entry_t mk(fu_t f, fu_op_t op, int idx, int rd, int rs1, int rs2,
                                      logic [XLEN-1:0] imm, bit ui);
    issue_entry_t e;
    e = '0;
    e.fu = f; e.operation = op; e.idx = ScoreboardIndex'(idx);
    e.rd = 5'(rd); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2);
    e.imm = imm; e.use_imm = ui; e.pc = 32'h1000 + 32'(idx) * 4;
    return e;
  endfunction

  task automatic idle();
    issue_valid = 0; flush = 0; wb = '0; commit_valid = 0;
    commit_idx = '0; commit_rd = '0; commit_data = '0;
  endtask

  task automatic neg();
    @(negedge clk);
    m_eval();
  endtask

  task automatic pos();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); instr = '0; flu_ready = 0; lsu_ready = 0;
    #2 rst_n = 0;
    m_reset();
    @(negedge clk);
    checks++; if (vals !== 5'b0) $display("FAIL reset_valids got=%b exp=%b", vals, 5'b0);
    if (vals !== 5'b0) failures++;
    checks++; if (fu_data !== '0) begin failures++; $display("FAIL reset_fu_data got=%h exp=0", fu_data); end
    checks++; if (pc !== '0 || is_rv16 !== 1'b0) begin failures++; $display("FAIL reset_pc got=%h/%b exp=0/0", pc, is_rv16); end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_independent();
    flu_ready = 1; lsu_ready = 1;
    instr = mk(FU_ALU, OP_ADD, 2, 5, 0, 0, 7, 1); issue_valid = 1;
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL addi_ready got=%b exp=1", issue_ready); end
    pos(); issue_valid = 0;
    neg();
    checks++; if (vals !== 5'b10000) begin failures++; $display("FAIL addi_valids got=%b exp=10000", vals); end
    checks++; if (fu_data.operand_a !== 32'h0) begin failures++; $display("FAIL addi_opa got=%h exp=0", fu_data.operand_a); end
    checks++; if (fu_data.operand_b !== 32'h7) begin failures++; $display("FAIL addi_opb got=%h exp=7", fu_data.operand_b); end
    checks++; if (fu_data.idx !== 3'd2) begin failures++; $display("FAIL addi_idx got=%0d exp=2", fu_data.idx); end
    pos();
  endtask

  task automatic test_raw_forward();
    instr = mk(FU_ALU, OP_ADD, 3, 6, 5, 5, 0, 0); issue_valid = 1;
    neg();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b exp=0", issue_ready); end
    checks++; if (vals !== 5'b0) begin failures++; $display("FAIL raw_pulse_end got=%b exp=0", vals); end
    pos(); wb[0] = '{valid: 1'b1, idx: 3'd2, data: 32'h7};
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL raw_fwd_ready got=%b exp=1", issue_ready); end
    pos(); wb = '0; issue_valid = 0;
    neg();
    checks++; if (vals !== 5'b10000) begin failures++; $display("FAIL raw_valids got=%b exp=10000", vals); end
    checks++; if (fu_data.operand_a !== 32'h7 || fu_data.operand_b !== 32'h7)
      begin failures++; $display("FAIL raw_ops got=%h/%h exp=7/7", fu_data.operand_a, fu_data.operand_b); end
    checks++; if (fu_data.idx !== 3'd3) begin failures++; $display("FAIL raw_idx got=%0d exp=3", fu_data.idx); end
    pos();
  endtask

  task automatic test_commit_collide();
    commit_valid = 1; commit_idx = 3'd2; commit_rd = 5'd5; commit_data = 32'h7;
    instr = mk(FU_ALU, OP_ADD, 4, 5, 0, 0, 1, 1); issue_valid = 1;
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL coll_ready got=%b exp=1", issue_ready); end
    pos(); commit_valid = 0; instr = mk(FU_ALU, OP_ADD, 6, 7, 5, 0, 0, 0);
    neg();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL coll_pending got=%b exp=0", issue_ready); end
    pos(); wb[0] = '{valid: 1'b1, idx: 3'd2, data: 32'h99};
    neg();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL coll_stale_idx got=%b exp=0", issue_ready); end
    pos(); wb[0] = '{valid: 1'b1, idx: 3'd4, data: 32'h55};
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL coll_new_idx got=%b exp=1", issue_ready); end
    pos(); wb = '0; issue_valid = 0;
    neg();
    checks++; if (fu_data.operand_a !== 32'h55) begin failures++; $display("FAIL coll_opa got=%h exp=55", fu_data.operand_a); end
    pos();
  endtask

  task automatic test_mdu_mask();
    instr = mk(FU_MDU, OP_MUL, 1, 8, 0, 0, 0, 0); issue_valid = 1;
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL mul1_ready got=%b exp=1", issue_ready); end
    pos(); instr = mk(FU_MDU, OP_MUL, 7, 9, 0, 0, 0, 0);
    neg();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL mul_mask got=%b exp=0", issue_ready); end
    checks++; if (vals !== 5'b00100) begin failures++; $display("FAIL mul1_valids got=%b exp=00100", vals); end
    pos();
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL mul2_ready got=%b exp=1", issue_ready); end
    checks++; if (vals !== 5'b0) begin failures++; $display("FAIL mul_gap got=%b exp=0", vals); end
    pos(); issue_valid = 0;
    neg();
    checks++; if (vals !== 5'b00100 || fu_data.idx !== 3'd7)
      begin failures++; $display("FAIL mul2_dispatch got=%b/%0d exp=00100/7", vals, fu_data.idx); end
    pos();
  endtask

  task automatic test_lsu_stall();
    lsu_ready = 0; instr = mk(FU_LSU, OP_LW, 5, 10, 0, 0, 32'h40, 1); issue_valid = 1;
    for (int i = 0; i < 3; i++) begin
      neg();
      checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL lw_stall%0d got=%b exp=0", i, issue_ready); end
      pos();
    end
    lsu_ready = 1;
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL lw_ready got=%b exp=1", issue_ready); end
    pos(); issue_valid = 0;
    neg();
    checks++; if (vals !== 5'b00001 || fu_data.idx !== 3'd5 || fu_data.operand_b !== 32'h40)
      begin failures++; $display("FAIL lw_dispatch got=%b/%0d/%h exp=00001/5/40", vals, fu_data.idx, fu_data.operand_b); end
    pos();
    neg();
    checks++; if (vals !== 5'b0) begin failures++; $display("FAIL lw_one_cycle got=%b exp=0", vals); end
    pos();
  endtask

  task automatic test_flush();
    instr = mk(FU_ALU, OP_ADD, 0, 12, 0, 0, 3, 1); issue_valid = 1;
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL fl_pre_ready got=%b exp=1", issue_ready); end
    pos(); flush = 1; instr = mk(FU_ALU, OP_ADD, 1, 13, 0, 0, 0, 0);
    neg();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL fl_force got=%b exp=0", issue_ready); end
    checks++; if (vals !== 5'b10000) begin failures++; $display("FAIL fl_pulse got=%b exp=10000", vals); end
    pos(); flush = 0; instr = mk(FU_ALU, OP_ADD, 2, 11, 5, 0, 0, 0);
    neg();
    checks++; if (vals !== 5'b0) begin failures++; $display("FAIL fl_leak got=%b exp=0", vals); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL fl_unpend got=%b exp=1", issue_ready); end
    pos(); issue_valid = 0;
    neg();
    checks++; if (fu_data.operand_a !== 32'h7) begin failures++; $display("FAIL fl_regfile got=%h exp=7", fu_data.operand_a); end
    pos();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      issue_entry_t e;
      e = '0;
      case ($urandom_range(0, 4))
        0: begin e.fu = FU_ALU; e.operation = $urandom_range(0, 1) ? OP_ADD : OP_SUB; end
        1: begin e.fu = FU_BU;  e.operation = OP_BEQ; end
        2: begin e.fu = FU_MDU; e.operation = OP_MUL; end
        3: begin e.fu = FU_CSR; e.operation = OP_CSRRW; end
        default: begin e.fu = FU_LSU; e.operation = $urandom_range(0, 1) ? OP_LW : OP_SW; end
      endcase
      e.idx = ScoreboardIndex'($urandom_range(0, NrSbEntries - 1));
      e.rd = 5'($urandom_range(0, 7)); e.rs1 = 5'($urandom_range(0, 7)); e.rs2 = 5'($urandom_range(0, 7));
      e.imm = $urandom; e.pc = $urandom; e.is_rv16 = 1'($urandom_range(0, 1));
      e.use_imm = 1'($urandom_range(0, 1)); e.use_pc = $urandom_range(0, 9) < 3;
      instr = e;
      issue_valid = $urandom_range(0, 9) < 7;
      flu_ready = $urandom_range(0, 9) < 8;
      lsu_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 99) < 3;
      for (int k = 0; k < WriteBackPorts; k++) begin
        wb[k].valid = $urandom_range(0, 99) < 35;
        wb[k].idx = ScoreboardIndex'($urandom_range(0, NrSbEntries - 1));
        wb[k].data = $urandom;
        if (issue_valid && wb[k].idx == e.idx) wb[k].valid = 1'b0;
      end
      if (wb[1].idx == wb[0].idx) wb[1].valid = 1'b0;
      commit_valid = $urandom_range(0, 9) < 3;
      commit_idx = ScoreboardIndex'($urandom_range(0, NrSbEntries - 1));
      commit_rd = 5'($urandom_range(0, 7));
      commit_data = $urandom;
      neg();
      checks++; if (issue_ready !== m_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, issue_ready, m_ready); end
      checks++; if (vals !== exp_v) begin failures++; $display("FAIL rnd_valids cyc=%0d got=%b exp=%b", n, vals, exp_v); end
      if (exp_v != 0) begin
        checks++;
        if (fu_data !== exp_fu || pc !== exp_pc || is_rv16 !== exp_rv16) begin
          failures++;
          $display("FAIL rnd_payload cyc=%0d got=%h/%h/%b exp=%h/%h/%b", n, fu_data, pc, is_rv16, exp_fu, exp_pc, exp_rv16);
        end
      end
      pos();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle(); flu_ready = 1;
    neg(); pos();
    instr = mk(FU_CSR, OP_CSRRW, 3, 4, 0, 0, 5, 1); issue_valid = 1;
    neg();
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", issue_ready); end
    pos(); issue_valid = 0;
    checks++; if (vals !== 5'b00010) begin failures++; $display("FAIL ar_pulse got=%b exp=00010", vals); end
    #2 rst_n = 0;
    #1;
    checks++; if (vals !== 5'b0 || fu_data !== '0)
      begin failures++; $display("FAIL ar_clear got=%b/%h exp=0/0", vals, fu_data); end
    m_reset();
    @(posedge clk); #1 rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw_forward();
    test_commit_collide();
    test_mdu_mask();
    test_lsu_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_read_operands.md
Name: issue_read_operands

Overview:
- Issue/operand-read stage sitting directly upstream of ex_stage.
- Accepts one decoded instruction per cycle from the scoreboard and resolves rs1/rs2 from the architectural register file, a per-scoreboard-entry result buffer, or same-cycle writeback forwarding.
- Drives registered fu_data plus one-hot FU valid pulses into ex_stage.
- Tracks the in-flight producer of every architectural register until commit.

Parameters:
- NrSbEntries, 8, scoreboard entries; ScoreboardIndex = $clog2(NrSbEntries).
- WriteBackPorts, 2, writeback ports from ex_stage (0 = flu, 1 = lsu).
- XLEN, 32, datapath width.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  kill in-flight dispatch and clear all pending state.
- issue_valid  in  1  scoreboard presents an instruction.
- issue_ready  out  1  instruction accepted this cycle (combinational).
- issue_instr  in  issue_entry_t  fields: idx, fu, operation, rs1, rs2, rd, imm, pc, is_rv16, use_imm, use_pc.
- flu_ready  in  1  ALU/BU/MDU/CSR path can accept.
- lsu_ready  in  1  LSU can accept.
- fu_data  out  fu_data_t  registered operands/op/imm/idx.
- pc  out  XLEN  registered pc of the dispatched instruction.
- is_rv16  out  1  registered compressed flag.
- alu_valid, bu_valid, mdu_valid, csr_valid, lsu_valid  out  1 each  one-hot, one-cycle dispatch pulses.
- wb  in  writeback_t[WriteBackPorts]  results {valid, idx, data} from ex_stage.
- commit_valid  in  1  head entry retires.
- commit_idx  in  ScoreboardIndex  retiring entry.
- commit_rd  in  5  retiring destination register.
- commit_data  in  XLEN  retiring value.

Behaviour:
- Reset (reset=0, async):
  - All *_valid outputs and fu_data/pc/is_rv16 = 0.
  - pending[31:0] = 0; rb_valid[NrSbEntries-1:0] = 0; regfile = 0.
- Operand resolution for source rs (rs1 or rs2), first matching rule wins:
  - rs==0 -> 0.
  - Otherwise, if pending[rs] is clear -> regfile value, with write-first bypass when commit_valid && commit_rd==rs in the same cycle.
  - Otherwise p = pend_idx[rs]:
    - any wb[k].valid && wb[k].idx==p -> wb[k].data (lowest k wins);
    - else rb_valid[p] -> rb_data[p];
    - else the operand is not ready.
- Operand selection:
  - operand_a = use_pc ? issue_instr.pc : rs1 value.
  - operand_b = use_imm ? imm : rs2 value. For LSU stores operand_b is always the rs2 value.
- Per-FU readiness:
  - fu_ok = lsu_ready for LSU; flu_ready for all other FUs.
  - The cycle after an MDU, CSR or LSU dispatch, the matching ready is masked to 0, because ex_stage ready lags the registered dispatch by one cycle.
- Accept condition: issue_ready = issue_valid && fu_ok && both required operands ready && !flush.
- Accept cycle: on accept the output register loads at the next edge. Exactly one of the five valids is high for that single cycle; otherwise all valids drop to 0. Latency is 1 cycle, accept to valid.
- Pending table:
  - On accept with rd!=0: pending[rd]=1, pend_idx[rd]=issue_instr.idx, and rb_valid[idx] is cleared (index reuse).
  - On commit: pending[commit_rd] is cleared only if pend_idx[commit_rd]==commit_idx.
  - If an accept with rd==r and a commit of r occur in the same cycle, the accept wins and pending stays set with the new idx.
- Result buffer: each wb[k].valid sets rb_valid[idx] and captures data. Commit of idx clears rb_valid[idx]. Writeback and commit to the same idx in one cycle resolve to clear.
- Regfile: written on commit_valid && commit_rd!=0. x0 is hard-wired to 0.
- flush: clears valids at the next edge, pending[], and rb_valid[]; issue_ready is forced to 0 in the flush cycle. Regfile is untouched.
- Asynchronous reset asserted mid-dispatch: outputs clear immediately, with no partial pulse.

Decomposition:
- OoO_pkg gains:
  - fu_t enum {FU_NONE, FU_ALU, FU_BU, FU_MDU, FU_CSR, FU_LSU};
  - issue_entry_t;
  - NrSbEntries.
- fu_data_t, writeback_t, WriteBackPorts and ScoreboardIndex are reused from the package.
- Sub-module: ooo_regfile (32x32, 2 async read ports, 1 sync write port, x0 = 0).
- Pending table, result buffer, forwarding mux and output register stay in the top module.

Test Plan:
- Independent ADDI x5 (idx 2, rs1=x0, imm 7) with flu_ready=1 -> issue_ready=1, next cycle alu_valid=1, operand_a=0, operand_b=7, idx=2, pending[5]=1.
- ADD x6,x5,x5 (idx 3) issued while x5 is pending on idx 2 with no result -> issue_ready=0. Then wb[0]={1,2,0x7} arrives -> same-cycle accept, operand_a=operand_b=0x7.
- Commit idx 2 (rd x5, data 0x7) in the same cycle as issue of rd=x5 (idx 4) -> regfile[5]=0x7, pending[5]=1, pend_idx[5]=4.
- MUL dispatched, then a second MUL presented the next cycle with flu_ready=1 -> masked, issue_ready=0 that cycle; accepted once flu_ready is seen after the mask.
- LW (idx 5) with lsu_ready=0 for 3 cycles -> issue_ready=0 for those cycles. lsu_ready=1 -> accepted, then lsu_valid pulses exactly one cycle with fu_data.idx=5.
- flush asserted in the cycle after an accept, with x5 pending -> no valid pulse leaks past the flush edge, pending[5]=0, and rs1=x5 is read from the regfile.
